tdm_demux_1to32: RTL and testbench
==================================

// Module: tdm_demux_1to32
// PURPOSE
//   Receive end of the 32-channel time-division link; the transmit end is the 32:1 mux tree stepping its select.
//   Takes one serial bit per accepted beat and routes beat k of a frame to lane k.
//   Frame alignment comes from a frame_sync flag on channel 0.
//   Publishes each complete frame as a parallel word with a one-cycle valid pulse.
//   Detects and recovers from sync loss.
// PARAMETERS
//   N_CH      32   channels per frame (>=2)
//   SEL_W      5   channel counter width, = clog2(N_CH)
//   LANE_REV   0   0: channel k -> dout[k]; 1: channel k -> dout[N_CH-1-k] (pairs with an inverted-select mux tree)
// PORTS
//   clk         in   1      rising-edge clock
//   rst_n       in   1      synchronous reset, active low
//   din         in   1      serial data bit
//   din_valid   in   1      din/frame_sync qualified this cycle (no backpressure; always accepted)
//   frame_sync  in   1      with din_valid: this beat is channel 0
//   dout        out  N_CH   last complete frame, lane-mapped per LANE_REV
//   dout_valid  out  1      1-cycle pulse: dout updated this cycle
//   ch_idx      out  SEL_W  channel index the next accepted beat will fill
//   locked      out  1      1 after a full frame is received cleanly; 0 after any sync error
//   sync_err    out  1      1-cycle pulse on a framing violation
// BEHAVIOUR
//   Reset (rst_n=0 at posedge):
//   - state=HUNT; ch_idx=0; assembly reg=0; dout=0.
//   - dout_valid=0, locked=0, sync_err=0.
//   - Reset wins over all inputs; a partial frame in progress is discarded.
//   Beat = cycle with din_valid=1. Cycles with din_valid=0 change nothing except clearing the pulses.
//   HUNT:
//   - Beat with frame_sync=0 is dropped silently; no sync_err.
//   - Beat with frame_sync=1: store din as channel 0; ch_idx<=1; go to RECV.
//   RECV, beat at ch_idx=c:
//   - c!=0, frame_sync=0: store din as channel c; ch_idx<=c+1.
//   - c==N_CH-1: the last beat also completes the frame:
//     - dout <= full frame including this bit, registered; visible the cycle after the beat.
//     - dout_valid=1 for that one cycle; locked<=1; ch_idx<=0 (wrap); stay in RECV.
//   - c==0, frame_sync=1: normal start of the next frame; store as channel 0; ch_idx<=1.
//   - c==0, frame_sync=0: missing sync. Pulse sync_err; locked<=0; drop the beat; ch_idx<=0; go to HUNT.
//   - c!=0, frame_sync=1: early sync (resync).
//     - Pulse sync_err; locked<=0; discard the partial frame.
//     - Take the beat as channel 0; ch_idx<=1; stay in RECV.
//     - dout is not updated.
//   Frame-complete rules:
//   - dout holds its value between completions; it is never partially updated.
//   - dout_valid and sync_err are never asserted in the same cycle.
//   - Assembly-register bits for channels not yet written in the current frame keep stale values.
//     Only complete frames are published, so the stale bits are never visible.
//   Latency: last beat at cycle t -> dout/dout_valid at cycle t+1.
//   Throughput: one frame per N_CH beats; back-to-back frames need no idle cycle.
//   ch_idx and locked are registered; they are valid from the cycle after reset.
// TESTING
//   1. Reset, then 32 beats with sync on beat 0, data=0xA5C3_0F71 (bit k on beat k), LANE_REV=0
//      -> dout=0xA5C3_0F71 and dout_valid=1 one cycle after beat 31; locked=1.
//   2. Two back-to-back frames 0xFFFF_0000 then 0x1234_5678, random din_valid gaps
//      -> two dout_valid pulses; dout matches each frame; no sync_err.
//   3. In HUNT, 10 beats without sync, then a valid frame
//      -> no sync_err; the first dout_valid shows the valid frame.
//   4. Frame sync asserted again on beat 17
//      -> sync_err pulse, locked=0, no dout_valid; the frame restarted at that beat completes correctly.
//   5. After lock, beat at ch_idx=0 with frame_sync=0 -> sync_err, HUNT, locked=0, ch_idx=0.
//   6. rst_n=0 mid-frame (ch_idx=9) -> all outputs 0 next cycle.
//      LANE_REV=1 repeat of test 1 -> dout=bit-reverse(0xA5C3_0F71)=0x8EF0_C3A5.

Source files
------------

// File: rtl/tdm_demux_1to32.sv
// -----------------------------------------------------------------------------
// tdm_demux_1to32
//   Receive end of an N_CH-channel time-division serial link. Each accepted
//   beat carries one bit. Beat k of a frame belongs to channel k. The frame_sync
//   flag marks channel 0.
//   Each completed frame appears on dout as one parallel word. A one-cycle
//   dout_valid pulse accompanies it. The block detects a lost sync and
//   recovers from it.
//
//   Handshake: din/frame_sync are qualified by din_valid. There is no
//   backpressure, so every cycle with din_valid=1 is consumed as one beat.
//   dout_valid and sync_err are single-cycle pulses. They are never high
//   together.
//
// Ports
//   clk         in   1      rising-edge clock
//   rst_n       in   1      synchronous reset, active low
//   din         in   1      serial data bit
//   din_valid   in   1      din/frame_sync qualified this cycle
//   frame_sync  in   1      with din_valid: this beat is channel 0
//   dout        out  N_CH   last complete frame, lane-mapped per LANE_REV
//   dout_valid  out  1      1-cycle pulse: dout updated this cycle
//   ch_idx      out  SEL_W  channel the next accepted beat will fill
//   locked      out  1      1 after a clean full frame, 0 after a sync error
//   sync_err    out  1      1-cycle pulse on a framing violation
//   state_dbg   out  1      current FSM state (0 = HUNT, 1 = RECV)
// -----------------------------------------------------------------------------
module tdm_demux_1to32 #(
    parameter int N_CH     = 32,
    parameter int SEL_W    = 5,
    parameter int LANE_REV = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [N_CH-1:0]  dout,
    output logic             dout_valid,
    output logic [SEL_W-1:0] ch_idx,
    output logic             locked,
    output logic             sync_err,
    output logic             state_dbg
);

    typedef enum logic {
        ST_HUNT = 1'b0,
        ST_RECV = 1'b1
    } state_t;

    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);
    localparam logic [SEL_W-1:0] CH_ONE  = SEL_W'(1);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] ch_idx_q, ch_idx_d;
    logic [N_CH-1:0]  asm_q, asm_d;
    logic [N_CH-1:0]  dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             locked_q, locked_d;
    logic             sync_err_q, sync_err_d;

    // The completed frame is the assembly register with the final channel
    // taken straight from the current beat. This lets dout load in the same
    // cycle as the last beat.
    logic [N_CH-1:0]  frame_full;
    logic [N_CH-1:0]  frame_mapped;

    always_comb begin
        frame_full           = asm_q;
        frame_full[N_CH-1]   = din;
        frame_mapped         = frame_full;
        if (LANE_REV != 0) begin
            for (int k = 0; k < N_CH; k++) begin
                frame_mapped[k] = frame_full[N_CH-1-k];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ch_idx_d     = ch_idx_q;
        asm_d        = asm_q;
        dout_d       = dout_q;
        locked_d     = locked_q;
        dout_valid_d = 1'b0;
        sync_err_d   = 1'b0;

        if (din_valid) begin
            case (state_q)
                ST_HUNT: begin
                    // Beats without sync are dropped silently while hunting.
                    if (frame_sync) begin
                        asm_d[0] = din;
                        ch_idx_d = CH_ONE;
                        state_d  = ST_RECV;
                    end
                end

                ST_RECV: begin
                    if (ch_idx_q == '0) begin
                        if (frame_sync) begin
                            asm_d[0] = din;
                            ch_idx_d = CH_ONE;
                        end else begin
                            // Missing sync: drop the beat and hunt again.
                            sync_err_d = 1'b1;
                            locked_d   = 1'b0;
                            ch_idx_d   = '0;
                            state_d    = ST_HUNT;
                        end
                    end else if (frame_sync) begin
                        // Early sync: abandon the partial frame. Restart
                        // with this beat as channel 0. dout is untouched.
                        sync_err_d = 1'b1;
                        locked_d   = 1'b0;
                        asm_d[0]   = din;
                        ch_idx_d   = CH_ONE;
                    end else if (ch_idx_q == LAST_CH) begin
                        asm_d[ch_idx_q] = din;
                        dout_d          = frame_mapped;
                        dout_valid_d    = 1'b1;
                        locked_d        = 1'b1;
                        ch_idx_d        = '0;
                    end else begin
                        asm_d[ch_idx_q] = din;
                        ch_idx_d        = ch_idx_q + CH_ONE;
                    end
                end

                default: begin
                    state_d  = ST_HUNT;
                    ch_idx_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_HUNT;
            ch_idx_q     <= '0;
            asm_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ch_idx_q     <= ch_idx_d;
            asm_q        <= asm_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            locked_q     <= locked_d;
            sync_err_q   <= sync_err_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign ch_idx     = ch_idx_q;
    assign locked     = locked_q;
    assign sync_err   = sync_err_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_tdm_demux_1to32.sv
module tb_tdm_demux_1to32;

  localparam int N = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          din = 1'b0;
  logic          din_valid = 1'b0;
  logic          frame_sync = 1'b0;
  logic [N-1:0]  dout, dout_rev;
  logic          dout_valid, dout_valid_rev;
  logic [4:0]    ch_idx, ch_idx_rev;
  logic          locked, locked_rev;
  logic          sync_err, sync_err_rev;
  logic          state_dbg, state_dbg_rev;

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  int n_err    = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  tdm_demux_1to32 #(.N_CH(N), .SEL_W(5), .LANE_REV(0)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .frame_sync(frame_sync), .dout(dout), .dout_valid(dout_valid),
    .ch_idx(ch_idx), .locked(locked), .sync_err(sync_err),
    .state_dbg(state_dbg)
  );

  tdm_demux_1to32 #(.N_CH(N), .SEL_W(5), .LANE_REV(1)) dut_rev (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .frame_sync(frame_sync), .dout(dout_rev), .dout_valid(dout_valid_rev),
    .ch_idx(ch_idx_rev), .locked(locked_rev), .sync_err(sync_err_rev),
    .state_dbg(state_dbg_rev)
  );

  // ---------------- reference model ----------------
  // A frame is a list of received bits. Publishing packs the list into a word.
  bit           m_hunt;
  bit           m_q[$];
  logic [N-1:0] m_dout;
  logic         m_valid, m_err, m_locked;

  function automatic logic [N-1:0] bitrev(input logic [N-1:0] w);
    logic [N-1:0] r;
    for (int k = 0; k < N; k++) r[k] = w[N-1-k];
    return r;
  endfunction

  task automatic model_reset();
    m_hunt = 1'b1;
    m_q.delete();
    m_dout = '0;
    m_valid = 1'b0;
    m_err = 1'b0;
    m_locked = 1'b0;
  endtask

  task automatic model_beat(input logic s, input logic d);
    if (m_hunt) begin
      if (s) begin
        m_q.delete();
        m_q.push_back(d);
        m_hunt = 1'b0;
      end
    end else if (m_q.size() == 0) begin
      if (s) m_q.push_back(d);
      else begin
        m_err = 1'b1;
        m_locked = 1'b0;
        m_hunt = 1'b1;
      end
    end else if (s) begin
      m_err = 1'b1;
      m_locked = 1'b0;
      m_q.delete();
      m_q.push_back(d);
    end else begin
      m_q.push_back(d);
      if (m_q.size() == N) begin
        for (int k = 0; k < N; k++) m_dout[k] = m_q[k];
        m_valid = 1'b1;
        m_locked = 1'b1;
        m_q.delete();
      end
    end
  endtask

  function automatic int m_ch();
    return m_hunt ? 0 : m_q.size();
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all();
    if (dout_valid === 1'b1) n_valid++;
    if (sync_err === 1'b1) n_err++;
    chk("dout", dout, m_dout);
    chk("dout_rev", dout_rev, bitrev(m_dout));
    chk("dout_valid", {31'b0, dout_valid}, {31'b0, m_valid});
    chk("sync_err", {31'b0, sync_err}, {31'b0, m_err});
    chk("locked", {31'b0, locked}, {31'b0, m_locked});
    chk("ch_idx", {27'b0, ch_idx}, N'(m_ch()));
    chk("rev_valid", {31'b0, dout_valid_rev}, {31'b0, m_valid});
    chk("rev_err", {31'b0, sync_err_rev}, {31'b0, m_err});
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic v, input logic s, input logic d);
    din_valid = v;
    frame_sync = s;
    din = d;
    @(posedge clk);
    m_valid = 1'b0;
    m_err = 1'b0;
    if (!rst_n) model_reset();
    else if (v) model_beat(s, d);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic send_frame(input logic [N-1:0] w, input bit gaps);
    for (int k = 0; k < N; k++) begin
      if (gaps) begin
        for (int g = 0; g < 3 && $urandom_range(0, 2) == 0; g++) step(1'b0, 1'b0, 1'($urandom));
      end
      step(1'b1, k == 0, w[k]);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       v, s, d;
    logic       e_err, e_lock;
    logic [4:0] e_ch;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int v0, e0;
    // inputs: v s d | expected: sync_err locked ch_idx
    vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0};  // hunt: drop
    vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0};  // idle ignored
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd1};  // sync found
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2};  // gap holds
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd1};  // early sync
    vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd2};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3};
    vecs[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd1};  // early sync again
    vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1};

    model_reset();
    do_reset();
    chk("rst_dout", dout, '0);
    chk("rst_ch", {27'b0, ch_idx}, '0);
    chk("rst_lock", {31'b0, locked}, '0);

    for (int i = 0; i < 10; i++) begin
      step(vecs[i].v, vecs[i].s, vecs[i].d);
      chk("tbl_err", {31'b0, sync_err}, {31'b0, vecs[i].e_err});
      chk("tbl_lock", {31'b0, locked}, {31'b0, vecs[i].e_lock});
      chk("tbl_ch", {27'b0, ch_idx}, {27'b0, vecs[i].e_ch});
    end

    // test 1 + LANE_REV=1 repeat
    do_reset();
    send_frame(32'hA5C3_0F71, 1'b0);
    chk("t1_dout", dout, 32'hA5C3_0F71);
    chk("t1_valid", {31'b0, dout_valid}, 1);
    chk("t1_lock", {31'b0, locked}, 1);
    chk("t1_rev", dout_rev, 32'h8EF0_C3A5);
    step(1'b0, 1'b0, 1'b0);
    chk("t1_pulse_end", {31'b0, dout_valid}, 0);

    // test 2: back-to-back frames with gaps
    v0 = n_valid; e0 = n_err;
    send_frame(32'hFFFF_0000, 1'b1);
    chk("t2_f0", dout, 32'hFFFF_0000);
    send_frame(32'h1234_5678, 1'b1);
    chk("t2_f1", dout, 32'h1234_5678);
    chk("t2_pulses", N'(n_valid - v0), 2);
    chk("t2_errs", N'(n_err - e0), 0);

    // test 3: hunt drops unsynced beats silently
    do_reset();
    v0 = n_valid; e0 = n_err;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'($urandom));
    send_frame(32'h5A5A_1234, 1'b0);
    chk("t3_dout", dout, 32'h5A5A_1234);
    chk("t3_pulses", N'(n_valid - v0), 1);
    chk("t3_errs", N'(n_err - e0), 0);

    // test 4: early sync on beat 17, restarted frame completes
    send_frame(32'h0F0F_0F0F, 1'b0);
    v0 = n_valid;
    for (int k = 0; k < 17; k++) step(1'b1, k == 0, 1'($urandom));
    step(1'b1, 1'b1, 1'b1);
    chk("t4_err", {31'b0, sync_err}, 1);
    chk("t4_lock", {31'b0, locked}, 0);
    chk("t4_ch", {27'b0, ch_idx}, 1);
    chk("t4_dout_hold", dout, 32'h0F0F_0F0F);
    for (int k = 1; k < N; k++) step(1'b1, 1'b0, k[0]);
    chk("t4_dout", dout, 32'hAAAA_AAAB);
    chk("t4_pulses", N'(n_valid - v0), 1);
    chk("t4_relock", {31'b0, locked}, 1);

    // test 5: missing sync after lock
    step(1'b1, 1'b0, 1'b1);
    chk("t5_err", {31'b0, sync_err}, 1);
    chk("t5_lock", {31'b0, locked}, 0);
    chk("t5_ch", {27'b0, ch_idx}, 0);
    step(1'b1, 1'b0, 1'b1);
    chk("t5_hunt_quiet", {31'b0, sync_err}, 0);

    // test 6: reset mid-frame
    send_frame(32'hCAFE_F00D, 1'b0);
    for (int k = 0; k < 9; k++) step(1'b1, k == 0, 1'b1);
    chk("t6_ch9", {27'b0, ch_idx}, 9);
    do_reset();
    chk("t6_dout", dout, '0);
    chk("t6_ch", {27'b0, ch_idx}, '0);
    chk("t6_lock", {31'b0, locked}, '0);
    chk("t6_pulses", {30'b0, dout_valid, sync_err}, '0);

    // randomized run against the model
    for (int i = 0; i < 4000; i++) begin
      logic v, s;
      v = ($urandom_range(0, 3) != 0);
      if (m_hunt || m_q.size() == 0) s = ($urandom_range(0, 7) != 0);
      else s = ($urandom_range(0, 60) == 0);
      step(v, s, 1'($urandom));
      if ($urandom_range(0, 999) == 0) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
